// File: rtl/issue_pkg.sv
// Shared issue-stage definitions: execution-unit codes, eu_ready bit positions
// and the unit-readiness lookup used by the warp issue arbiter.
package issue_pkg;

  localparam int EX_BITS  = 3;
  localparam int EU_COUNT = 5;

  typedef enum logic [EX_BITS-1:0] {
    EX_NOP = 3'd0,
    EX_ALU = 3'd1,
    EX_LSU = 3'd2,
    EX_CSR = 3'd3,
    EX_FPU = 3'd4,
    EX_GPU = 3'd5
  } ex_type_e;

  localparam int EU_ALU = 0;
  localparam int EU_LSU = 1;
  localparam int EU_CSR = 2;
  localparam int EU_FPU = 3;
  localparam int EU_GPU = 4;

  function automatic logic unit_ready(input logic [EX_BITS-1:0] ex,
                                      input logic [EU_COUNT-1:0] eu);
    case (ex)
      EX_ALU:  return eu[EU_ALU];
      EX_LSU:  return eu[EU_LSU];
      EX_CSR:  return eu[EU_CSR];
      EX_FPU:  return eu[EU_FPU];
      EX_GPU:  return eu[EU_GPU];
      // NOP and the unused codes 6/7 never wait on a unit
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/warp_issue_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after
// start, wrapping from N-1 to 0. With start tied to 0 it is a lowest-index picker.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    int j;
    j         = 0;
    gnt       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!any_valid && req[j]) begin
        any_valid = 1'b1;
        gnt[j]    = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/warp_issue_arbiter.sv
// Per-cycle warp issue arbiter: round-robin with starvation override into a
// single valid/ready output slot. `reset` is active-low. ISSUE_PERF_EN adds stall counters.
module warp_issue_arbiter
  import issue_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int DATAW        = 128,
  parameter int STARVE_LIMIT = 15,
  parameter int PERF_W       = 32,
  localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WARPS-1:0]       warp_valid,
  input  logic [NUM_WARPS*3-1:0]     warp_ex_type,
  input  logic [NUM_WARPS*DATAW-1:0] warp_data,
  output logic [NUM_WARPS-1:0]       warp_ready,
  input  logic [4:0]                 eu_ready,
  output logic                       out_valid,
  output logic [WID_W-1:0]           out_wid,
  output logic [2:0]                 out_ex_type,
  output logic [DATAW-1:0]           out_data,
  input  logic                       out_ready
`ifdef ISSUE_PERF_EN
  ,
  output logic [PERF_W-1:0]          perf_stall_cycles,
  output logic [PERF_W-1:0]          perf_unit_block_cycles
`endif
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  if (NUM_WARPS < 1 || NUM_WARPS > 32 || STARVE_LIMIT < 1 || PERF_W < 1) begin : g_bad_cfg
    $error("warp_issue_arbiter: illegal parameter combination");
  end

  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] starved;
  logic [AGE_W-1:0]     age [NUM_WARPS];
  logic [WID_W-1:0]     rr_ptr;
  logic                 load;
  logic [NUM_WARPS-1:0] rr_gnt, st_gnt, gnt;
  logic [WID_W-1:0]     rr_idx, st_idx, gnt_idx;
  logic                 rr_any, st_any, gnt_any;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? AGE_MAX : a + 1'b1;
  endfunction

  function automatic logic [WID_W-1:0] ptr_next(input logic [WID_W-1:0] p);
    return (int'(p) == NUM_WARPS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    load    = !out_valid || out_ready;
    elig    = '0;
    starved = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w]    = warp_valid[w] && unit_ready(warp_ex_type[EX_BITS*w +: EX_BITS], eu_ready);
      starved[w] = elig[w] && (age[w] == AGE_MAX);
    end
  end

  rr_picker #(.N(NUM_WARPS), .IDX_W(WID_W)) u_rr_pick (
    .req       (elig),
    .start     (rr_ptr),
    .gnt       (rr_gnt),
    .idx       (rr_idx),
    .any_valid (rr_any)
  );

  // Starved warps are served lowest index first, independent of rr_ptr.
  rr_picker #(.N(NUM_WARPS), .IDX_W(WID_W)) u_starve_pick (
    .req       (starved),
    .start     ('0),
    .gnt       (st_gnt),
    .idx       (st_idx),
    .any_valid (st_any)
  );

  always_comb begin
    gnt_any = load && reset && rr_any;
    gnt     = '0;
    gnt_idx = rr_idx;
    if (gnt_any) begin
      gnt     = st_any ? st_gnt : rr_gnt;
      gnt_idx = st_any ? st_idx : rr_idx;
    end
  end

  assign warp_ready = gnt;

  // Stage boundary: output slot, round-robin pointer and per-warp ages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_wid     <= '0;
      out_ex_type <= '0;
      out_data    <= '0;
      rr_ptr      <= '0;
      for (int w = 0; w < NUM_WARPS; w++) age[w] <= '0;
    end else begin
      if (gnt_any) begin
        out_valid   <= 1'b1;
        out_wid     <= gnt_idx;
        out_ex_type <= warp_ex_type[EX_BITS*gnt_idx +: EX_BITS];
        out_data    <= warp_data[DATAW*gnt_idx +: DATAW];
        rr_ptr      <= ptr_next(gnt_idx);
      end else if (load) begin
        out_valid <= 1'b0;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        age[w] <= (gnt[w] || !warp_valid[w]) ? '0 : age_sat_inc(age[w]);
      end
    end
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles      <= '0;
      perf_unit_block_cycles <= '0;
    end else begin
      if (|warp_valid && !gnt_any) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (|warp_valid && !(|elig)) perf_unit_block_cycles <= perf_unit_block_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Self-checking bench for warp_issue_arbiter: directed scenarios plus randomized
// traffic against a behavioural model. Perf checks compile only with ISSUE_PERF_EN.
module tb_warp_issue_arbiter;

  localparam int NW   = 4;
  localparam int DW   = 32;
  localparam int SL   = 15;
  localparam int PW   = 16;
  localparam int WIDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NW-1:0]   warp_valid = '0;
  logic [NW*3-1:0] warp_ex_type = '0;
  logic [NW*DW-1:0] warp_data = '0;
  logic [NW-1:0]   warp_ready;
  logic [4:0]      eu_ready = '0;
  logic            out_valid;
  logic [WIDW-1:0] out_wid;
  logic [2:0]      out_ex_type;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
`ifdef ISSUE_PERF_EN
  logic [PW-1:0]   perf_stall_cycles;
  logic [PW-1:0]   perf_unit_block_cycles;
`endif

  always #5 clk = ~clk;

  warp_issue_arbiter #(
    .NUM_WARPS(NW), .DATAW(DW), .STARVE_LIMIT(SL), .PERF_W(PW)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .warp_valid   (warp_valid),
    .warp_ex_type (warp_ex_type),
    .warp_data    (warp_data),
    .warp_ready   (warp_ready),
    .eu_ready     (eu_ready),
    .out_valid    (out_valid),
    .out_wid      (out_wid),
    .out_ex_type  (out_ex_type),
    .out_data     (out_data),
    .out_ready    (out_ready)
`ifdef ISSUE_PERF_EN
    ,
    .perf_stall_cycles      (perf_stall_cycles),
    .perf_unit_block_cycles (perf_unit_block_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit              m_valid;
  logic [WIDW-1:0] m_wid;
  logic [2:0]      m_ex;
  logic [DW-1:0]   m_data;
  int              m_rr;
  int              m_age [NW];
  int              m_stall;
  int              m_block;

  function automatic logic [2:0] ex_of(int w);
    return warp_ex_type[3*w +: 3];
  endfunction

  function automatic logic [DW-1:0] data_of(int w);
    return warp_data[DW*w +: DW];
  endfunction

  // Codes 1..5 map to eu_ready bits 0..4; everything else needs no unit.
  function automatic bit elig(int w);
    int code;
    code = int'(ex_of(w));
    if (!warp_valid[w]) return 1'b0;
    if (code >= 1 && code <= 5) return eu_ready[code-1];
    return 1'b1;
  endfunction

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    for (int w = 0; w < NW; w++)
      if (elig(w) && m_age[w] == SL) return w;
    for (int k = 0; k < NW; k++)
      if (elig((m_rr + k) % NW)) return (m_rr + k) % NW;
    return -1;
  endfunction

  function automatic logic [NW-1:0] onehot(int g);
    logic [NW-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_wid = '0; m_ex = '0; m_data = '0; m_rr = 0;
    m_stall = 0; m_block = 0;
    for (int w = 0; w < NW; w++) m_age[w] = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic cycle();
    int g;
    bit load, any_e;
    g     = model_grant();
    load  = !m_valid || out_ready;
    any_e = 1'b0;
    for (int w = 0; w < NW; w++) if (elig(w)) any_e = 1'b1;
    if (rst_n) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_wid = WIDW'(g); m_ex = ex_of(g); m_data = data_of(g);
        m_rr = (g + 1) % NW;
      end else if (load) begin
        m_valid = 1'b0;
      end
      if (|warp_valid && g < 0) m_stall = (m_stall + 1) % (1 << PW);
      if (|warp_valid && !any_e) m_block = (m_block + 1) % (1 << PW);
      for (int w = 0; w < NW; w++)
        m_age[w] = (w == g || !warp_valid[w]) ? 0 : ((m_age[w] < SL) ? m_age[w] + 1 : SL);
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NW; w++) warp_data[DW*w +: DW] = $urandom;
  endtask

  task automatic set_all(logic [NW-1:0] v, logic [2:0] ex);
    warp_valid = v;
    for (int w = 0; w < NW; w++) warp_ex_type[3*w +: 3] = ex;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_all('1, 3'd1);
    eu_ready = 5'b11111;
    out_ready = 1'b1;
    rand_data();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (warp_ready !== '0) begin n_fail++; $display("FAIL reset_warp_ready got=%b want=0000", warp_ready); end
    n_tests++;
    if (out_valid !== 1'b0 || out_wid !== '0 || out_ex_type !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b wid=%0d ex=%0d data=%h want all zero", out_valid, out_wid, out_ex_type, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NW-1:0] exp_r;
    logic [DW-1:0] exp_d;
    do_reset();
    set_all('1, 3'd1);
    eu_ready = 5'b11111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      exp_d = data_of(k % NW);
      #1;
      exp_r = '0;
      exp_r[k % NW] = 1'b1;
      n_tests++;
      if (warp_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, warp_ready, exp_r); end
      cycle();
      n_tests++;
      if (out_valid !== 1'b1 || out_wid !== WIDW'(k % NW) || out_data !== exp_d) begin
        n_fail++;
        $display("FAIL rr_slot[%0d] got v=%b wid=%0d data=%h want v=1 wid=%0d data=%h", k, out_valid, out_wid, out_data, k % NW, exp_d);
      end
    end
  endtask

  task automatic test_unit_block();
    do_reset();
    warp_valid = 4'b0111;
    warp_ex_type = {3'd0, 3'd1, 3'd2, 3'd2};
    eu_ready = 5'b11101;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_data();
      #1;
      n_tests++;
      if (warp_ready !== 4'b0100) begin n_fail++; $display("FAIL block_grant[%0d] got=%b want=0100", i, warp_ready); end
      cycle();
    end
    eu_ready = 5'b11111;
    #1;
    n_tests++;
    if (warp_ready !== 4'b0001) begin n_fail++; $display("FAIL starve_first got=%b want=0001", warp_ready); end
    cycle();
    n_tests++;
    if (out_wid !== 2'd0 || out_ex_type !== 3'd2) begin n_fail++; $display("FAIL starve_first_slot got wid=%0d ex=%0d want wid=0 ex=2", out_wid, out_ex_type); end
    n_tests++;
    if (warp_ready !== 4'b0010) begin n_fail++; $display("FAIL starve_second got=%b want=0010", warp_ready); end
    cycle();
    n_tests++;
    if (out_wid !== 2'd1) begin n_fail++; $display("FAIL starve_second_slot got wid=%0d want 1", out_wid); end
  endtask

  task automatic test_starvation();
    do_reset();
    warp_valid = 4'b1111;
    warp_ex_type = {3'd4, 3'd1, 3'd1, 3'd1};
    eu_ready = 5'b10111;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_data();
      #1;
      n_tests++;
      if (warp_ready !== onehot(i % 3)) begin n_fail++; $display("FAIL starve_rr[%0d] got=%b want=%b", i, warp_ready, onehot(i % 3)); end
      cycle();
    end
    // rr_ptr now points at warp 1, but warp 3 has waited STARVE_LIMIT cycles.
    eu_ready = 5'b11111;
    #1;
    n_tests++;
    if (warp_ready !== 4'b1000) begin n_fail++; $display("FAIL starve_override got=%b want=1000", warp_ready); end
    cycle();
    n_tests++;
    if (out_wid !== 2'd3 || out_ex_type !== 3'd4) begin n_fail++; $display("FAIL starve_override_slot got wid=%0d ex=%0d want wid=3 ex=4", out_wid, out_ex_type); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0;
    do_reset();
    set_all('1, 3'd1);
    eu_ready = 5'b11111;
    out_ready = 1'b1;
    rand_data();
    d0 = data_of(0);
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      for (int w = 0; w < NW; w++) warp_ex_type[3*w +: 3] = 3'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (warp_ready !== '0) begin n_fail++; $display("FAIL bp_no_pop[%0d] got=%b want=0000", i, warp_ready); end
      cycle();
      n_tests++;
      if (out_valid !== 1'b1 || out_wid !== 2'd0 || out_ex_type !== 3'd1 || out_data !== d0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b wid=%0d ex=%0d data=%h want v=1 wid=0 ex=1 data=%h", i, out_valid, out_wid, out_ex_type, out_data, d0);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (warp_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release got=%b want=0010", warp_ready); end
    cycle();
    n_tests++;
    if (out_wid !== 2'd1 || out_ex_type !== m_ex || out_data !== m_data) begin
      n_fail++;
      $display("FAIL bp_release_slot got wid=%0d ex=%0d data=%h want wid=1 ex=%0d data=%h", out_wid, out_ex_type, out_data, m_ex, m_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_all('1, 3'd1);
    eu_ready = 5'b11111;
    out_ready = 1'b0;
    rand_data();
    cycle();
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_setup got v=%b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_wid !== '0 || warp_ready !== '0) begin
      n_fail++;
      $display("FAIL areset_drop got v=%b wid=%0d data=%h ready=%b want all zero", out_valid, out_wid, out_data, warp_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (warp_ready !== 4'b0001) begin n_fail++; $display("FAIL areset_first_grant got=%b want=0001", warp_ready); end
    cycle();
    n_tests++;
    if (out_valid !== 1'b1 || out_wid !== 2'd0) begin n_fail++; $display("FAIL areset_first_slot got v=%b wid=%0d want v=1 wid=0", out_valid, out_wid); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int w = 0; w < NW; w++) begin
        warp_valid[w] = ($urandom_range(0, 7) != 0);
        warp_ex_type[3*w +: 3] = 3'($urandom_range(0, 7));
      end
      rand_data();
      eu_ready = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant();
      n_tests++;
      if (warp_ready !== onehot(g)) begin n_fail++; $display("FAIL rand_grant[%0d] got=%b want=%b", i, warp_ready, onehot(g)); end
      cycle();
      n_tests++;
      if (out_valid !== m_valid || (m_valid && (out_wid !== m_wid || out_ex_type !== m_ex || out_data !== m_data))) begin
        n_fail++;
        $display("FAIL rand_slot[%0d] got v=%b wid=%0d ex=%0d data=%h want v=%b wid=%0d ex=%0d data=%h",
                 i, out_valid, out_wid, out_ex_type, out_data, m_valid, m_wid, m_ex, m_data);
      end
`ifdef ISSUE_PERF_EN
      n_tests++;
      if (perf_stall_cycles !== PW'(m_stall) || perf_unit_block_cycles !== PW'(m_block)) begin
        n_fail++;
        $display("FAIL rand_perf[%0d] got stall=%0d block=%0d want stall=%0d block=%0d",
                 i, perf_stall_cycles, perf_unit_block_cycles, m_stall, m_block);
      end
`endif
    end
  endtask

`ifdef ISSUE_PERF_EN
  task automatic test_perf();
    do_reset();
    warp_valid = 4'b1111;
    warp_ex_type = {3'd4, 3'd3, 3'd2, 3'd1};
    eu_ready = 5'b00000;
    out_ready = 1'b1;
    repeat (10) cycle();
    n_tests++;
    if (perf_stall_cycles !== PW'(10) || perf_unit_block_cycles !== PW'(10)) begin
      n_fail++;
      $display("FAIL perf_counts got stall=%0d block=%0d want 10 10", perf_stall_cycles, perf_unit_block_cycles);
    end
    set_all('1, 3'd0);
    #1;
    n_tests++;
    if (warp_ready !== 4'b0001) begin n_fail++; $display("FAIL perf_nop_grant got=%b want=0001", warp_ready); end
    cycle();
    n_tests++;
    if (out_valid !== 1'b1 || perf_stall_cycles !== PW'(10)) begin
      n_fail++;
      $display("FAIL perf_nop_slot got v=%b stall=%0d want v=1 stall=10", out_valid, perf_stall_cycles);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_unit_block();
    test_starvation();
    test_backpressure();
    test_async_reset();
`ifdef ISSUE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
